// File: rtl/multu_hilo_pkg.sv
// Shared MIPS decode constants for the multiply/HI-LO block and its neighbours.
// Holds the R-type funct codes seen on the alu_ctl Signal output and the EX
// result-mux select codes used when MFHI/MFLO forward HI/LO into the pipeline.
package multu_hilo_pkg;

  // R-type funct codes as produced by alu_ctl.
  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_JR    = 6'd8;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;

  // EX result mux selects.
  typedef enum logic [1:0] {
    MUX_ALU = 2'b00,
    MUX_HI  = 2'b01,
    MUX_LO  = 2'b10,
    MUX_SLL = 2'b11
  } mux_sel_e;

endpackage

// File: rtl/multu_hilo_if.sv
// Request/result bundle between the EX stage and the multiplier.
//   funct  : funct/Signal from alu_ctl (master -> slave)
//   dataA  : multiplicand, rs          (master -> slave)
//   dataB  : multiplier, rt            (master -> slave)
//   hi_out : architectural HI          (slave -> master)
//   lo_out : architectural LO          (slave -> master)
//   busy   : iteration sequence active (slave -> master)
//   done   : one-cycle commit pulse    (slave -> master)
interface multu_hilo_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       funct;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy;
  logic             done;

  modport master (
    output funct, dataA, dataB,
    input  hi_out, lo_out, busy, done
  );

  modport slave (
    input  funct, dataA, dataB,
    output hi_out, lo_out, busy, done
  );
endinterface

// File: rtl/multu_hilo_mul_step.sv
// One iteration of the unsigned shift-add multiplier, purely combinational.
//   acc, plier : current {acc,plier} partial product / remaining multiplier
//   mcand      : multiplicand
//   acc_next, plier_next : {sum,plier} >> 1, carry of the add entering acc MSB
module mul_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] plier,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] plier_next
);
  logic [WIDTH:0] sum;

  // Extra MSB keeps the carry so it is not lost before the shift.
  assign sum        = {1'b0, acc} + (plier[0] ? {1'b0, mcand} : '0);
  assign acc_next   = sum[WIDTH:1];
  assign plier_next = {sum[0], plier[WIDTH-1:1]};
endmodule

// File: rtl/multu_hilo.sv
// Multi-cycle unsigned multiplier (MULTU) with architectural HI/LO registers.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : multu_hilo_if slave (funct, dataA, dataB in; hi_out, lo_out, busy, done out)
// A request (funct == F_MULTU in IDLE) runs WIDTH shift-add steps; the product
// commits to HI/LO on the last step, done pulses once, and the block waits in
// HOLD until funct leaves F_MULTU so a held request yields one multiply.
module multu_hilo #(
  parameter int         WIDTH   = 32,
  parameter logic [5:0] F_MULTU = multu_hilo_pkg::F_MULTU
) (
  input  logic         clk,
  input  logic         rst,
  multu_hilo_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state, state_nx;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] mcand, acc, plier;
  logic [WIDTH-1:0] acc_nx, plier_nx;
  logic [WIDTH-1:0] hi, lo;
  logic             done_q;
  logic             load, step, last;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .plier      (plier),
    .mcand      (mcand),
    .acc_next   (acc_nx),
    .plier_next (plier_nx)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.funct == F_MULTU) begin
          state_nx = RUN;
          load     = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (counter == CNT_W'(WIDTH - 1)) begin
          last     = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (bus.funct != F_MULTU) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values of the others, matching the hardware it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: work registers are cleared too, so an aborted run leaves no
      // stale partial product visible to a later debug read or X-propagation.
      state   <= IDLE;
      counter <= '0;
      mcand   <= '0;
      acc     <= '0;
      plier   <= '0;
      hi      <= '0;
      lo      <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= last;
      if (load) begin
        mcand   <= bus.dataA;
        acc     <= '0;
        plier   <= bus.dataB;
        counter <= '0;
      end else if (step) begin
        acc     <= acc_nx;
        plier   <= plier_nx;
        counter <= counter + 1'b1;
      end
      // HI/LO only move on the final step; no partial products are exposed.
      if (last) begin
        hi <= acc_nx;
        lo <= plier_nx;
      end
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = done_q;
  assign bus.hi_out = hi;
  assign bus.lo_out = lo;
endmodule

// File: tb/tb_multu_hilo.sv
// Self-checking bench for multu_hilo: table vectors, random operands checked
// against a plain 64-bit product, and hand-written reset / re-arm sequences.
module tb_multu_hilo;
  import multu_hilo_pkg::*;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  multu_hilo_if #(.WIDTH(WIDTH)) bus ();

  multu_hilo #(.WIDTH(WIDTH), .F_MULTU(F_MULTU)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle request; operands and funct are scrambled right after
  // acceptance, which the block must ignore.
  task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] hi0;
    logic [31:0] lo0;
    int          busy_n;
    bit          partial;
    hi0     = bus.hi_out;
    lo0     = bus.lo_out;
    busy_n  = 0;
    partial = 1'b0;
    bus.funct = F_MULTU;
    bus.dataA = a;
    bus.dataB = b;
    step();
    bus.funct = F_ADD;
    bus.dataA = $urandom;
    bus.dataB = $urandom;
    while (bus.busy === 1'b1 && busy_n < 100) begin
      busy_n++;
      if (bus.hi_out !== hi0 || bus.lo_out !== lo0 || bus.done !== 1'b0) partial = 1'b1;
      step();
    end
    check({name, " busy cycles"}, 64'(busy_n), 64'(WIDTH));
    check({name, " no partial update"}, 64'(partial), 64'd0);
    check({name, " done"}, 64'(bus.done), 64'd1);
    check({name, " product"}, {bus.hi_out, bus.lo_out}, {exp_hi, exp_lo});
    step();
    check({name, " done width"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int          pulses;
    int          first_k;
    int          second_k;
    int          n;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] prod;

    bus.funct = F_SLL;
    bus.dataA = '0;
    bus.dataB = '0;
    repeat (2) step();
    rst = 1'b0;
    check("reset hi", 64'(bus.hi_out), 64'd0);
    check("reset lo", 64'(bus.lo_out), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);

    vecs[0] = '{32'd3,          32'd5,          32'd0,          32'd15};
    vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   32'h00000001};
    vecs[2] = '{32'd0,          32'd1234,       32'd0,          32'd0};
    vecs[3] = '{32'd1,          32'hFFFFFFFF,   32'd0,          32'hFFFFFFFF};
    vecs[4] = '{32'h00010000,   32'h00010000,   32'd1,          32'd0};
    vecs[5] = '{32'h80000000,   32'd2,          32'd1,          32'd0};
    vecs[6] = '{32'h12345678,   32'h10,         32'd1,          32'h23456780};
    for (int i = 0; i < 7; i++) begin
      run_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // Asynchronous reset away from any clock edge clears outputs at once.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async rst hi", 64'(bus.hi_out), 64'd0);
    check("async rst lo", 64'(bus.lo_out), 64'd0);
    check("async rst busy", 64'(bus.busy), 64'd0);
    check("async rst done", 64'(bus.done), 64'd0);
    repeat (2) step();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      ra   = $urandom;
      rb   = (i % 4 == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
      prod = 64'(ra) * 64'(rb);
      run_mul($sformatf("rand%0d", i), ra, rb, prod[63:32], prod[31:0]);
    end

    // dataA changed mid-run must not affect the product.
    bus.funct = F_MULTU;
    bus.dataA = 32'h00010000;
    bus.dataB = 32'h00010000;
    step();
    bus.funct = F_SLL;
    repeat (5) step();
    bus.dataA = 32'd7;
    bus.dataB = 32'd3;
    n = 0;
    while (bus.done !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    check("midrun change done", 64'(bus.done), 64'd1);
    check("midrun change product", {bus.hi_out, bus.lo_out}, 64'h0000000100000000);
    step();

    // Held request yields one multiply; re-arm needs funct to leave F_MULTU.
    pulses    = 0;
    first_k   = 0;
    second_k  = 0;
    bus.funct = F_MULTU;
    bus.dataA = 32'd3;
    bus.dataB = 32'd5;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus.done === 1'b1) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
    end
    bus.funct = F_SLL;
    step();
    if (bus.done === 1'b1) pulses++;
    bus.funct = F_MULTU;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus.done === 1'b1) begin
        pulses++;
        if (second_k == 0) second_k = k;
      end
    end
    check("held pulses", 64'(pulses), 64'd2);
    check("held first latency", 64'(first_k), 64'd33);
    check("rearm latency", 64'(second_k), 64'd33);
    check("rearm product", {bus.hi_out, bus.lo_out}, 64'd15);
    bus.funct = F_SLL;
    repeat (2) step();

    // Reset mid-run aborts: no done, HI/LO cleared, next request works.
    bus.funct = F_MULTU;
    bus.dataA = 32'd3;
    bus.dataB = 32'd5;
    step();
    bus.funct = F_SLL;
    repeat (10) step();
    rst = 1'b1;
    #1;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    step();
    rst    = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.done === 1'b1) pulses++;
    end
    check("abort no done", 64'(pulses), 64'd0);
    check("abort hilo stays", {bus.hi_out, bus.lo_out}, 64'd0);
    run_mul("after abort", 32'd7, 32'd6, 32'd0, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
